dmem_wait_responder: RTL and testbench

//  Data-memory responder for the MEM stage of mips_5_stage: answers the pipeline's load/store

---
 rtl/dmem_wait_responder_pkg.sv | 15 +
 rtl/dmem_sp_ram.sv | 38 +++
 rtl/dmem_wait_responder.sv | 96 +++++++++
 tb/tb_dmem_wait_responder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_wait_responder_pkg.sv
// Shared types and constants for the wait-state data-memory responder.
// The FSM state encoding lives here so the RTL and any checkers can decode it the same way.
package dmem_wait_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;
  localparam int WRC_W  = 16;

endpackage

// File: rtl/dmem_sp_ram.sv
// Single-port synchronous RAM with one read/write port and a registered read.
// The read register only loads on a read, so it holds the last loaded word.
import dmem_wait_responder_pkg::*;

module dmem_sp_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [AW-1:0]     i_addr,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  // Contents deliberately have no reset: memory survives a pipeline reset.
  logic [WORD_W-1:0] RAM [DEPTH];
  logic [WORD_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      RAM[i_addr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= RAM[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_wait_responder.sv
// MEM-stage data memory with a programmable wait-state latency; stalls the pipeline
// while an access is in flight. Handshake: a request (memread_m|memwrite_m) is held by the
// pipeline while stall_m==1; the cycle with stall_m==0 after acceptance (RESP) completes it.
import dmem_wait_responder_pkg::*;

module dmem_wait_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memread_m,
  input  logic              memwrite_m,
  input  logic [31:0]       addr_m,
  input  logic [WORD_W-1:0] writedata_m,
  output logic [WORD_W-1:0] readdata_m,
  output logic              stall_m,
  output logic              err,
  output logic [WRC_W-1:0]  wr_count,
  output dmem_state_t       o_dbg_state
);

  localparam int AW = $clog2(DEPTH);

  dmem_state_t       r_state;
  dmem_state_t       w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [AW-1:0]     r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic              r_is_store;
  logic              r_err;
  logic [WRC_W-1:0]  r_wr_count;

  logic w_req;
  logic w_accept;
  logic w_fire;
  logic w_bad_req;
  logic w_unused_addr;

  assign w_req         = memread_m | memwrite_m;
  assign w_accept      = (r_state == IDLE) && w_req;
  assign w_fire        = (r_state == BUSY) && (r_cnt == '0);
  assign w_bad_req     = (addr_m[1:0] != 2'b00) || (memread_m && memwrite_m);
  // Address bits above the word index are intentionally ignored (index wraps).
  assign w_unused_addr = ^addr_m[31:AW+2];

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_req) w_next_state = BUSY;
      BUSY:    if (r_cnt == '0) w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_wr_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_addr     <= addr_m[AW+1:2];
        r_wdata    <= writedata_m;
        r_is_store <= memwrite_m;  // write wins when both are asserted
        r_cnt      <= CNT_W'(LATENCY - 1);
        if (w_bad_req) r_err <= 1'b1;
      end else if ((r_state == BUSY) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_fire && r_is_store && (r_wr_count != {WRC_W{1'b1}})) begin
        r_wr_count <= r_wr_count + 1'b1;
      end
    end
  end

  // Gating with reset drops a store whose commit edge coincides with reset.
  dmem_sp_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_fire && r_is_store && reset),
    .i_re    (w_fire && !r_is_store && reset),
    .i_addr  (r_addr),
    .i_wdata (r_wdata),
    .o_rdata (readdata_m)
  );

  assign stall_m     = reset && (w_accept || (r_state == BUSY));
  assign err         = r_err;
  assign wr_count    = r_wr_count;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Scoreboard bench: driver pushes expected responses from a word-array model, monitor
// pops and compares at each completed access (end of a stall run).
import dmem_wait_responder_pkg::*;

module tb_dmem_wait_responder;

  localparam int DEPTH   = 64;
  localparam int LATENCY = 2;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic [15:0] wrc;
  } resp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread_m, memwrite_m;
  logic [31:0] addr_m, writedata_m;
  logic [31:0] readdata_m;
  logic        stall_m, err;
  logic [15:0] wr_count;
  dmem_state_t dbg_state;

  int checks = 0;
  int errors = 0;

  resp_t       exp_q[$];
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_rd;
  logic        m_err;
  int          m_wrc;

  dmem_wait_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .memread_m   (memread_m),
    .memwrite_m  (memwrite_m),
    .addr_m      (addr_m),
    .writedata_m (writedata_m),
    .readdata_m  (readdata_m),
    .stall_m     (stall_m),
    .err         (err),
    .wr_count    (wr_count),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: memory is a flat word array indexed by (addr/4) mod DEPTH.
  task automatic model_access(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] d);
    resp_t r;
    int idx;
    idx = int'((a >> 2) % DEPTH);
    if (a[1:0] != 2'b00 || (rd && wr)) m_err = 1'b1;
    if (wr) begin
      m_mem[idx] = d;
      if (m_wrc < 65535) m_wrc++;
    end else begin
      m_rd = m_mem[idx];
    end
    r.rd  = m_rd;
    r.err = m_err;
    r.wrc = 16'(m_wrc);
    exp_q.push_back(r);
  endtask

  task automatic model_reset();
    m_rd  = '0;
    m_err = 1'b0;
    m_wrc = 0;
  endtask

  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d);
    int n;
    memread_m   = rd;
    memwrite_m  = wr;
    addr_m      = a;
    writedata_m = d;
    model_access(rd, wr, a, d);
    n = 0;
    forever begin
      @(negedge clk);
      if (!stall_m) break;
      n++;
      if (n > 40) begin
        errors++;
        $display("FAIL stall_timeout: stall_m held %0d cycles, required %0d", n, LATENCY + 1);
        break;
      end
    end
    // Inputs stay held through the RESP cycle, then drop.
    @(posedge clk); #1;
    memread_m  = 1'b0;
    memwrite_m = 1'b0;
    addr_m     = $urandom;
    writedata_m = $urandom;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_stall", {31'b0, stall_m}, 32'd0);
      chk("idle_rd_held", readdata_m, m_rd);
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_ram(input int idx);
    chk("ram_word", u_dut.u_ram.RAM[idx], m_mem[idx]);
  endtask

  // Monitor: a completed access is the first non-stall cycle after a stall run.
  initial begin
    int run;
    resp_t r;
    run = 0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        run = 0;
      end else if (stall_m) begin
        run++;
      end else if (run > 0) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp: response with empty expected queue");
        end else begin
          r = exp_q.pop_front();
          chk("stall_len", 32'(run), 32'(LATENCY + 1));
          chk("resp_rdata", readdata_m, r.rd);
          chk("resp_err", {31'b0, err}, {31'b0, r.err});
          chk("resp_wr_count", {16'b0, wr_count}, {16'b0, r.wrc});
          chk("resp_state", {30'b0, dbg_state}, {30'b0, RESP});
        end
        run = 0;
      end
    end
  end

  initial begin
    logic [31:0] a;
    int op, gap;
    reset = 1'b0; memread_m = 1'b0; memwrite_m = 1'b0; addr_m = '0; writedata_m = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_stall", {31'b0, stall_m}, 32'd0);
    chk("rst_rdata", readdata_m, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_wr_count", {16'b0, wr_count}, 32'd0);
    chk("rst_state", {30'b0, dbg_state}, {30'b0, IDLE});
    @(posedge clk); #1;

    // Basic store then load, back-to-back pair, idle hold.
    access(1'b0, 1'b1, 32'h4, 32'h1);
    chk_ram(1);
    access(1'b1, 1'b0, 32'h4, 32'h0);
    access(1'b0, 1'b1, 32'h8, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'h8, 32'h0);
    idle_cycles(3);

    // Misaligned store, wrapped address, read+write together.
    access(1'b0, 1'b1, 32'h6, 32'h7);
    chk_ram(1);
    access(1'b0, 1'b1, 32'h104, 32'h0000_0abc);
    chk_ram(1);
    access(1'b1, 1'b0, 32'h4, 32'h0);
    access(1'b1, 1'b1, 32'hC, 32'h5);
    chk_ram(3);
    idle_cycles(1);

    // Reset during BUSY of a store: store is dropped.
    access(1'b0, 1'b1, 32'h10, 32'h44);
    memwrite_m = 1'b1; addr_m = 32'h10; writedata_m = 32'h9;
    @(posedge clk); #1;
    reset = 1'b0; memwrite_m = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    chk("abort_state", {30'b0, dbg_state}, {30'b0, IDLE});
    chk("abort_stall", {31'b0, stall_m}, 32'd0);
    chk("abort_wr_count", {16'b0, wr_count}, 32'd0);
    chk_ram(4);
    @(posedge clk); #1;
    access(1'b1, 1'b0, 32'h10, 32'h0);

    // Fill every word so random loads have known data.
    for (int i = 0; i < DEPTH; i++) access(1'b0, 1'b1, 32'(i * 4), $urandom);

    for (int k = 0; k < 60; k++) begin
      a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, DEPTH - 1) << 2);
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      op = $urandom_range(0, 9);
      if (op == 0)      access(1'b1, 1'b1, a, $urandom);
      else if (op < 5)  access(1'b0, 1'b1, a, $urandom);
      else              access(1'b1, 1'b0, a, 32'h0);
      gap = $urandom_range(0, 2);
      if (gap > 0) idle_cycles(gap);
    end
    for (int i = 0; i < DEPTH; i += 9) chk_ram(i);

    repeat (2) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
